// File: rtl/vx_issue_pkg.sv
// Shared encodings and sizing helpers for the issue-stage warp arbiter.
package vx_issue_pkg;

  localparam int EX_BITS   = 3;
  localparam int NUM_UNITS = 5;

  typedef enum logic [EX_BITS-1:0] {
    EX_ALU = 3'd0,
    EX_LSU = 3'd1,
    EX_CSR = 3'd2,
    EX_FPU = 3'd3,
    EX_GPU = 3'd4
  } ex_type_e;

  function automatic int wid_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// Rotate-priority picker: first set request at or after i_ptr, wrapping modulo N.
module vx_rr_pick import vx_issue_pkg::*; #(
  parameter  int N = 4,
  localparam int W = wid_bits(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_valid,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_grant
);

  logic [W-1:0] w_idx;
  logic [W-1:0] w_cand;

  // Scan from the far end so the candidate closest to i_ptr is written last.
  always_comb begin
    o_valid = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = i_ptr + W'(k);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign o_idx = w_idx;

  always_comb begin
    o_grant = '0;
    if (o_valid) o_grant[w_idx] = 1'b1;
  end

endmodule

// File: rtl/vx_issue_arbiter.sv
// Per-cycle warp selector: round-robin over eligible ibuffer heads with a
// starvation override, gated by per-unit readiness and outstanding-request credits.
module vx_issue_arbiter import vx_issue_pkg::*; #(
  parameter  int NUM_WARPS    = 4,
  parameter  int NUM_UNITS    = vx_issue_pkg::NUM_UNITS,
  parameter  int EX_BITS      = vx_issue_pkg::EX_BITS,
  parameter  int CREDITS      = 4,
  parameter  int STARVE_LIMIT = 15,
  localparam int WID_BITS     = wid_bits(NUM_WARPS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_WARPS-1:0]           i_warp_valid,
  input  logic [NUM_WARPS*EX_BITS-1:0]   i_warp_ex_type,
  input  logic [NUM_WARPS-1:0]           i_warp_sb_ready,
  input  logic [NUM_UNITS-1:0]           i_unit_ready,
  input  logic [NUM_UNITS-1:0]           i_unit_done,
  input  logic                           i_issue_ready,
  output logic                           o_issue_valid,
  output logic [WID_BITS-1:0]            o_issue_wid,
  output logic [NUM_WARPS-1:0]           o_issue_grant,
  output logic [NUM_UNITS-1:0]           o_unit_no_credit,
  output logic                           o_starve_active
);

  localparam int AGE_BITS = 8;
  localparam int CR_BITS  = 4;
  localparam int EX_SPAN  = 1 << EX_BITS;

  logic [EX_BITS-1:0]   w_ex [NUM_WARPS];
  logic [EX_SPAN-1:0]   w_unit_avail;
  logic [NUM_WARPS-1:0] w_elig;
  logic [NUM_WARPS-1:0] w_starve_req;
  logic                 w_starve_hit;
  logic [WID_BITS-1:0]  w_starve_wid;
  logic                 w_rr_valid;
  logic [WID_BITS-1:0]  w_rr_wid;
  logic [NUM_WARPS-1:0] w_rr_grant;
  logic [WID_BITS-1:0]  w_wid;
  logic [EX_BITS-1:0]   w_win_ex;
  logic                 w_fire;
  logic [WID_BITS-1:0]  r_rr_ptr;

  // Encodings past the last unit are never available, which keeps bad ex_types ineligible.
  genvar gi;
  generate
    for (gi = NUM_UNITS; gi < EX_SPAN; gi++) begin : g_pad
      assign w_unit_avail[gi] = 1'b0;
    end

    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      logic [CR_BITS-1:0] r_credit;
      logic               w_take;
      logic               w_full;

      assign w_take = w_fire & (w_win_ex == EX_BITS'(gi));
      assign w_full = (r_credit == CR_BITS'(CREDITS));
      assign w_unit_avail[gi]     = i_unit_ready[gi] & (r_credit != '0);
      assign o_unit_no_credit[gi] = (r_credit == '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_credit <= CR_BITS'(CREDITS);
        else if (w_take && !i_unit_done[gi])
          r_credit <= r_credit - 1'b1;
        else if (i_unit_done[gi] && !w_take && !w_full)
          r_credit <= r_credit + 1'b1;
      end

      always @(posedge clk)
        if (rst_n)
          assert (!(i_unit_done[gi] && !w_take && w_full))
            else $warning("vx_issue_arbiter: credit return on unit %0d with no request outstanding", gi);
    end

    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
      logic [AGE_BITS-1:0] r_age;

      assign w_ex[gi]         = i_warp_ex_type[gi*EX_BITS +: EX_BITS];
      assign w_elig[gi]       = i_warp_valid[gi] & i_warp_sb_ready[gi] & w_unit_avail[w_ex[gi]];
      assign w_starve_req[gi] = w_elig[gi] & (r_age == AGE_BITS'(STARVE_LIMIT));

      // Age counts every valid cycle, scoreboard stalls included.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_age <= '0;
        else if ((w_fire && (w_wid == WID_BITS'(gi))) || !i_warp_valid[gi])
          r_age <= '0;
        else if (r_age != AGE_BITS'(STARVE_LIMIT))
          r_age <= r_age + 1'b1;
      end

      always @(posedge clk)
        if (rst_n && i_warp_valid[gi])
          assert (int'(w_ex[gi]) < NUM_UNITS)
            else $warning("vx_issue_arbiter: warp %0d head targets unknown unit %0d", gi, w_ex[gi]);
    end
  endgenerate

  always_comb begin
    w_starve_hit = 1'b0;
    w_starve_wid = '0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      if (w_starve_req[k]) begin
        w_starve_hit = 1'b1;
        w_starve_wid = WID_BITS'(k);
      end
    end
  end

  vx_rr_pick #(.N(NUM_WARPS)) u_rr_pick (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_rr_valid),
    .o_idx   (w_rr_wid),
    .o_grant (w_rr_grant)
  );

  assign w_wid    = w_starve_hit ? w_starve_wid : w_rr_wid;
  assign w_win_ex = w_ex[w_wid];

  assign o_issue_valid   = rst_n & w_rr_valid;
  assign o_issue_wid     = o_issue_valid ? w_wid : '0;
  assign o_issue_grant   = !o_issue_valid ? '0 :
                           w_starve_hit   ? (NUM_WARPS'(1) << w_starve_wid) : w_rr_grant;
  assign o_starve_active = o_issue_valid & w_starve_hit;
  assign w_fire          = o_issue_valid & i_issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rr_ptr <= '0;
    else if (w_fire)
      r_rr_ptr <= w_wid + 1'b1;
  end

endmodule

// File: tb/tb_vx_issue_arbiter.sv
// Self-checking bench for vx_issue_arbiter: directed table, corner sequences, random vs reference model.
module tb_vx_issue_arbiter;

  localparam int NW      = 4;
  localparam int NU      = 5;
  localparam int EXB     = 3;
  localparam int CREDITS = 4;
  localparam int LIMIT   = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NW-1:0]     warp_valid = '0;
  logic [NW*EXB-1:0] ex_type = '0;
  logic [NW-1:0]     sb_ready = '0;
  logic [NU-1:0]     unit_ready = '0;
  logic [NU-1:0]     unit_done = '0;
  logic              issue_ready = 1'b0;
  logic              o_valid;
  logic [1:0]        o_wid;
  logic [NW-1:0]     o_grant;
  logic [NU-1:0]     o_nocr;
  logic              o_starve;

  always #5 clk = ~clk;

  vx_issue_arbiter #(
    .NUM_WARPS(NW), .NUM_UNITS(NU), .EX_BITS(EXB), .CREDITS(CREDITS), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_warp_valid    (warp_valid),
    .i_warp_ex_type  (ex_type),
    .i_warp_sb_ready (sb_ready),
    .i_unit_ready    (unit_ready),
    .i_unit_done     (unit_done),
    .i_issue_ready   (issue_ready),
    .o_issue_valid   (o_valid),
    .o_issue_wid     (o_wid),
    .o_issue_grant   (o_grant),
    .o_unit_no_credit(o_nocr),
    .o_starve_active (o_starve)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_age [NW];
  int m_cred[NU];
  int m_ptr;

  logic          obs_valid;
  logic [1:0]    obs_wid;
  logic          obs_starve;
  logic [NU-1:0] obs_nocr;

  typedef struct {
    logic [NW-1:0] valid;
    logic [NU-1:0] done;
    logic          irdy;
    logic          e_valid;
    logic [1:0]    e_wid;
    logic [NU-1:0] e_nocr;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [NW-1:0] v, input logic [NW*EXB-1:0] ex, input logic [NW-1:0] sb,
                        input logic [NU-1:0] ur, input logic [NU-1:0] dn, input logic ir);
    warp_valid = v; ex_type = ex; sb_ready = sb; unit_ready = ur; unit_done = dn; issue_ready = ir;
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) m_age[w] = 0;
    for (int u = 0; u < NU; u++) m_cred[u] = CREDITS;
    m_ptr = 0;
  endfunction

  function automatic int head_ex(input int w);
    return int'(ex_type[w*EXB +: EXB]);
  endfunction

  function automatic void model_eval(output bit v, output int wid, output bit st);
    bit elig[NW];
    int ex;
    v = 0; wid = 0; st = 0;
    for (int w = 0; w < NW; w++) begin
      ex = head_ex(w);
      elig[w] = warp_valid[w] && sb_ready[w] && (ex < NU) && unit_ready[ex] && (m_cred[ex] > 0);
    end
    for (int w = 0; w < NW; w++)
      if (!v && elig[w] && m_age[w] == LIMIT) begin v = 1; st = 1; wid = w; end
    for (int k = 0; k < NW; k++)
      if (!v && elig[(m_ptr + k) % NW]) begin v = 1; wid = (m_ptr + k) % NW; end
  endfunction

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model over the edge.
  task automatic step(input string tag);
    bit v, st, fire, take;
    int wid;
    logic [NW-1:0] eg;
    logic [NU-1:0] enc;
    #2;
    model_eval(v, wid, st);
    eg = v ? (NW'(1) << wid) : '0;
    for (int u = 0; u < NU; u++) enc[u] = (m_cred[u] == 0);
    obs_valid = o_valid; obs_wid = o_wid; obs_starve = o_starve; obs_nocr = o_nocr;
    chk({tag, ".issue_valid"}, 32'(o_valid), 32'(v));
    if (v) chk({tag, ".issue_wid"}, 32'(o_wid), 32'(wid));
    chk({tag, ".issue_grant"}, 32'(o_grant), 32'(eg));
    chk({tag, ".starve_active"}, 32'(o_starve), 32'(st));
    chk({tag, ".unit_no_credit"}, 32'(o_nocr), 32'(enc));
    $display("[%0t] %s v=%b ex=%h sb=%b ur=%b dn=%b rdy=%b -> valid=%b wid=%0d starve=%b nocr=%b",
             $time, tag, warp_valid, ex_type, sb_ready, unit_ready, unit_done, issue_ready,
             o_valid, o_wid, o_starve, o_nocr);
    @(posedge clk);
    fire = v && issue_ready;
    for (int u = 0; u < NU; u++) begin
      take = fire && (head_ex(wid) == u);
      if (take && !unit_done[u]) m_cred[u]--;
      else if (!take && unit_done[u] && m_cred[u] < CREDITS) m_cred[u]++;
    end
    for (int w = 0; w < NW; w++) begin
      if (fire && w == wid) m_age[w] = 0;
      else if (warp_valid[w]) m_age[w] = (m_age[w] < LIMIT) ? m_age[w] + 1 : LIMIT;
      else m_age[w] = 0;
    end
    if (fire) m_ptr = (wid + 1) % NW;
    #1;
  endtask

  // Entered at posedge+1; leaves at posedge+1 with reset released and the model cleared.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("reset.issue_valid", 32'(o_valid), 32'd0);
    chk("reset.issue_grant", 32'(o_grant), 32'd0);
    chk("reset.issue_wid", 32'(o_wid), 32'd0);
    chk("reset.unit_no_credit", 32'(o_nocr), 32'd0);
    chk("reset.starve_active", 32'(o_starve), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    model_reset();
    tbl[0] = '{4'hF, 5'h00, 1'b1, 1'b1, 2'd0, 5'h00};
    tbl[1] = '{4'hF, 5'h00, 1'b1, 1'b1, 2'd1, 5'h00};
    tbl[2] = '{4'hF, 5'h00, 1'b1, 1'b1, 2'd2, 5'h00};
    tbl[3] = '{4'hF, 5'h00, 1'b1, 1'b1, 2'd3, 5'h00};
    tbl[4] = '{4'hF, 5'h00, 1'b1, 1'b0, 2'd0, 5'h01};
    tbl[5] = '{4'hF, 5'h01, 1'b1, 1'b0, 2'd0, 5'h01};
    tbl[6] = '{4'hF, 5'h00, 1'b1, 1'b1, 2'd0, 5'h00};
    tbl[7] = '{4'hF, 5'h00, 1'b1, 1'b0, 2'd0, 5'h01};

    // Eligible inputs during reset: outputs must still be forced low.
    set_in(4'hF, 12'h000, 4'hF, 5'h1F, 5'h00, 1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // Directed table: ALU round-robin, credit exhaustion, one-cycle credit return latency.
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].valid, 12'h000, 4'hF, 5'h1F, tbl[i].done, tbl[i].irdy);
      #2;
      chk($sformatf("tbl%0d.issue_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d.issue_wid", i), 32'(o_wid), 32'(tbl[i].e_wid));
      chk($sformatf("tbl%0d.issue_grant", i), 32'(o_grant),
          tbl[i].e_valid ? 32'(NW'(1) << tbl[i].e_wid) : 32'd0);
      chk($sformatf("tbl%0d.unit_no_credit", i), 32'(o_nocr), 32'(tbl[i].e_nocr));
      chk($sformatf("tbl%0d.starve_active", i), 32'(o_starve), 32'd0);
      $display("[%0t] tbl%0d valid=%b wid=%0d nocr=%b", $time, i, o_valid, o_wid, o_nocr);
      @(posedge clk);
      #1;
    end

    // LSU: simultaneous fire and done leaves the credit unchanged.
    do_reset();
    set_in(4'b0001, 12'h001, 4'hF, 5'h1F, 5'h00, 1'b1);
    repeat (3) step("lsu_take");
    unit_done = 5'b00010;
    repeat (3) step("lsu_take_done");
    unit_done = 5'b00000;
    step("lsu_last");
    step("lsu_empty");
    chk("lsu_empty.valid", 32'(obs_valid), 32'd0);
    chk("lsu_empty.nocr1", 32'(obs_nocr[1]), 32'd1);

    // Starvation: warp 3 ages behind the scoreboard, then wins over rr_ptr.
    do_reset();
    set_in(4'hF, 12'h000, 4'b0111, 5'h1F, 5'h01, 1'b1);
    repeat (20) step("starve_wait");
    sb_ready = 4'hF;
    step("starve_grant");
    chk("starve_grant.wid", 32'(obs_wid), 32'd3);
    chk("starve_grant.active", 32'(obs_starve), 32'd1);
    step("starve_after");
    chk("starve_after.active", 32'(obs_starve), 32'd0);

    // Scoreboard hold: warp 1 blocked, then granted within NUM_WARPS fires.
    do_reset();
    set_in(4'hF, 12'h000, 4'b1101, 5'h1F, 5'h01, 1'b1);
    repeat (6) step("sb_hold");
    sb_ready = 4'hF;
    seen = 0;
    for (int i = 0; i < NW; i++) begin
      step("sb_release");
      if (obs_valid && obs_wid == 2'd1) seen = 1;
    end
    chk("sb_release.warp1_granted", 32'(seen), 32'd1);

    // Unit not ready (FPU) and out-of-range ex_type on warp 1.
    do_reset();
    set_in(4'b0111, 12'h0F0, 4'hF, 5'b10111, 5'h00, 1'b0);
    step("unit_block");
    chk("unit_block.wid", 32'(obs_wid), 32'd0);
    issue_ready = 1'b1;
    repeat (5) step("unit_block_fire");

    // Asynchronous reset mid-stream with ALU credits exhausted.
    do_reset();
    set_in(4'hF, 12'h000, 4'hF, 5'h1F, 5'h00, 1'b1);
    repeat (4) step("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset.valid", 32'(o_valid), 32'd0);
    chk("async_reset.grant", 32'(o_grant), 32'd0);
    chk("async_reset.nocr", 32'(o_nocr), 32'd0);
    chk("async_reset.starve", 32'(o_starve), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    warp_valid = 4'b0110;
    step("post_reset");
    chk("post_reset.wid", 32'(obs_wid), 32'd1);
    repeat (4) step("post_reset_fire");

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int w = 0; w < NW; w++) begin
        warp_valid[w] = ($urandom_range(0, 9) < 8);
        sb_ready[w]   = ($urandom_range(0, 3) != 0);
        ex_type[w*EXB +: EXB] = EXB'($urandom_range(0, NU - 1));
      end
      for (int u = 0; u < NU; u++) begin
        unit_ready[u] = ($urandom_range(0, 4) != 0);
        unit_done[u]  = (m_cred[u] < CREDITS) && ($urandom_range(0, 2) == 0);
      end
      issue_ready = ($urandom_range(0, 9) < 7);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
